// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and parameter sanity helpers for the
// two-road traffic light controller.
package traffic_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned LAMP_W  = 2;

   typedef enum logic [STATE_W-1:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALLRED_A  = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALLRED_B  = 3'd5,
      PED_WALK  = 3'd6,
      FLASH     = 3'd7
   } state_t;

   localparam logic [LAMP_W-1:0] LAMP_RED    = 2'b00;
   localparam logic [LAMP_W-1:0] LAMP_GREEN  = 2'b01;
   localparam logic [LAMP_W-1:0] LAMP_YELLOW = 2'b10;
   localparam logic [LAMP_W-1:0] LAMP_DARK   = 2'b11;

   typedef struct packed {
      logic [LAMP_W-1:0] ns;
      logic [LAMP_W-1:0] ew;
   } lamp_pair_t;

   // A duration fits when it is non-zero and DUR-1 is representable in w bits.
   function automatic bit cnt_fits(input int unsigned cyc, input int unsigned w);
      if (cyc == 0) return 1'b0;
      if (w >= 32) return 1'b1;
      return (cyc - 1) < (32'd1 << w);
   endfunction

   // Lamp pair shown for a given state; blink only matters in FLASH.
   function automatic lamp_pair_t decode_lamps(input state_t s, input logic blink);
      lamp_pair_t l;
      l.ns = LAMP_RED;
      l.ew = LAMP_RED;
      case (s)
         NS_GREEN:  l.ns = LAMP_GREEN;
         NS_YELLOW: l.ns = LAMP_YELLOW;
         EW_GREEN:  l.ew = LAMP_GREEN;
         EW_YELLOW: l.ew = LAMP_YELLOW;
         FLASH: begin
            l.ns = blink ? LAMP_YELLOW : LAMP_DARK;
            l.ew = blink ? LAMP_YELLOW : LAMP_DARK;
         end
         default: ;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer: load has priority, decrements while dec=1,
// and reports when the count has reached zero.
module phase_timer #(
   parameter int unsigned          CNT_W   = 8,
   parameter logic [CNT_W-1:0]     RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= RST_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with latched pedestrian request,
// flashing night mode and run/freeze enable.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_CYC  = 8,
   parameter int unsigned YELLOW_CYC = 2,
   parameter int unsigned ALLRED_CYC = 1,
   parameter int unsigned PED_CYC    = 4,
   parameter int unsigned FLASH_HALF = 2,
   parameter int unsigned CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              ped_req,
   input  logic              flash_mode,
   output logic [LAMP_W-1:0] ns_signal,
   output logic [LAMP_W-1:0] ew_signal,
   output logic              ped_walk,
   output logic [STATE_W-1:0] phase
);

   if (!(cnt_fits(GREEN_CYC, CNT_W) && cnt_fits(YELLOW_CYC, CNT_W) &&
         cnt_fits(ALLRED_CYC, CNT_W) && cnt_fits(PED_CYC, CNT_W) &&
         cnt_fits(FLASH_HALF, CNT_W))) begin : g_param_err
      $error("traffic_light_ctrl: a phase duration is zero or does not fit CNT_W");
   end

   state_t           state, state_nx;
   logic             ped_pending, ped_pending_nx;
   logic             blink, blink_nx;
   logic             ret_ns, ret_ns_nx;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic             tmr_zero_c;
   lamp_pair_t       lamps_nx;

   function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   return CNT_W'(GREEN_CYC - 1);
         NS_YELLOW, EW_YELLOW: return CNT_W'(YELLOW_CYC - 1);
         PED_WALK:             return CNT_W'(PED_CYC - 1);
         FLASH:                return CNT_W'(FLASH_HALF - 1);
         default:              return CNT_W'(ALLRED_CYC - 1);
      endcase
   endfunction

   phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (CNT_W'(ALLRED_CYC - 1))
   ) u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (en),
      .zero_c   (tmr_zero_c)
   );

   // State, pending request, return target and blink registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ALLRED_B;
         ped_pending <= 1'b0;
         blink       <= 1'b1;
         ret_ns      <= 1'b1;
      end else begin
         state       <= state_nx;
         ped_pending <= ped_pending_nx;
         blink       <= blink_nx;
         ret_ns      <= ret_ns_nx;
      end
   end

   // Next state: flash_mode overrides expiry, expiry overrides hold.
   always_comb begin
      state_nx       = state;
      ped_pending_nx = ped_pending | (ped_req && (state != PED_WALK));
      blink_nx       = blink;
      ret_ns_nx      = ret_ns;
      tmr_load       = 1'b0;
      tmr_load_val   = CNT_W'(FLASH_HALF - 1);

      if (flash_mode) begin
         if (state != FLASH) begin
            state_nx = FLASH;
            blink_nx = 1'b1;
            tmr_load = 1'b1;
         end else if (en && tmr_zero_c) begin
            blink_nx = ~blink;
            tmr_load = 1'b1;
         end
      end else if (state == FLASH) begin
         state_nx     = ALLRED_B;
         tmr_load     = 1'b1;
         tmr_load_val = dur_m1(ALLRED_B);
      end else if (en && tmr_zero_c) begin
         case (state)
            NS_GREEN:  state_nx = NS_YELLOW;
            NS_YELLOW: state_nx = ALLRED_A;
            EW_GREEN:  state_nx = EW_YELLOW;
            EW_YELLOW: state_nx = ALLRED_B;
            ALLRED_A, ALLRED_B: begin
               if (ped_pending_nx) begin
                  state_nx       = PED_WALK;
                  ped_pending_nx = 1'b0;
                  ret_ns_nx      = (state == ALLRED_B);
               end else begin
                  state_nx = (state == ALLRED_A) ? EW_GREEN : NS_GREEN;
               end
            end
            PED_WALK:  state_nx = ret_ns ? NS_GREEN : EW_GREEN;
            default:   state_nx = ALLRED_B;
         endcase
         tmr_load     = 1'b1;
         tmr_load_val = dur_m1(state_nx);
      end

      lamps_nx = decode_lamps(state_nx, blink_nx);
   end

   // Outputs registered from the next-state decode so lamps change with the state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ns_signal <= LAMP_RED;
         ew_signal <= LAMP_RED;
         ped_walk  <= 1'b0;
         phase     <= STATE_W'(ALLRED_B);
      end else begin
         ns_signal <= lamps_nx.ns;
         ew_signal <= lamps_nx.ew;
         ped_walk  <= (state_nx == PED_WALK);
         phase     <= STATE_W'(state_nx);
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: phase/lamp sequences checked
// segment by segment against hand-computed run lengths.
module tb_traffic_light_ctrl;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       en = 1'b1;
   logic       ped_req = 1'b0;
   logic       flash_mode = 1'b0;
   logic [1:0] ns_signal;
   logic [1:0] ew_signal;
   logic       ped_walk;
   logic [2:0] phase;

   int n_checks = 0;
   int n_pass   = 0;

   traffic_light_ctrl dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .ped_req    (ped_req),
      .flash_mode (flash_mode),
      .ns_signal  (ns_signal),
      .ew_signal  (ew_signal),
      .ped_walk   (ped_walk),
      .phase      (phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // n consecutive cycles, each sampled on the falling edge.
   task automatic seg(input string tag, input int ph, input int ns, input int ew,
                      input int walk, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "/phase"}, int'(phase), ph);
         check({tag, "/ns"}, int'(ns_signal), ns);
         check({tag, "/ew"}, int'(ew_signal), ew);
         check({tag, "/walk"}, int'(ped_walk), walk);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "/phase"}, int'(phase), 5);
      check({tag, "/ns"}, int'(ns_signal), 0);
      check({tag, "/ew"}, int'(ew_signal), 0);
      check({tag, "/walk"}, int'(ped_walk), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset
      #2 rstn = 1'b0;
      #2 check_reset_state("por");
      @(negedge clk);
      @(negedge clk);
      check_reset_state("por_hold");
      rstn = 1'b1;

      // Free run, two full 22-cycle periods
      for (int p = 0; p < 2; p++) begin
         seg("run_nsg", 0, 1, 0, 0, 8);
         seg("run_nsy", 1, 2, 0, 0, 2);
         seg("run_ara", 2, 0, 0, 0, 1);
         seg("run_ewg", 3, 0, 1, 0, 8);
         seg("run_ewy", 4, 0, 2, 0, 2);
         seg("run_arb", 5, 0, 0, 0, 1);
      end

      // One-cycle pedestrian pulse during NS green
      seg("ped_nsg", 0, 1, 0, 0, 1);
      ped_req = 1'b1;
      seg("ped_nsg", 0, 1, 0, 0, 1);
      ped_req = 1'b0;
      seg("ped_nsg", 0, 1, 0, 0, 6);
      seg("ped_nsy", 1, 2, 0, 0, 2);
      seg("ped_ara", 2, 0, 0, 0, 1);
      seg("ped_walk", 6, 0, 0, 1, 4);
      seg("ped_ewg", 3, 0, 1, 0, 8);
      seg("ped_ewy", 4, 0, 2, 0, 2);
      seg("ped_arb", 5, 0, 0, 0, 1);
      seg("ped_nsg2", 0, 1, 0, 0, 8);
      seg("ped_nsy2", 1, 2, 0, 0, 2);
      seg("ped_ara2", 2, 0, 0, 0, 1);

      // Request held high from EW green through the whole walk
      seg("hold_ewg", 3, 0, 1, 0, 2);
      ped_req = 1'b1;
      seg("hold_ewg", 3, 0, 1, 0, 6);
      seg("hold_ewy", 4, 0, 2, 0, 2);
      seg("hold_arb", 5, 0, 0, 0, 1);
      seg("hold_walk", 6, 0, 0, 1, 4);
      ped_req = 1'b0;
      seg("hold_nsg", 0, 1, 0, 0, 8);
      seg("hold_nsy", 1, 2, 0, 0, 2);
      seg("hold_ara", 2, 0, 0, 0, 1);

      // Flash mode entered during EW green, then dropped during a dark half
      seg("fl_ewg", 3, 0, 1, 0, 3);
      flash_mode = 1'b1;
      seg("fl_on1", 7, 2, 2, 0, 2);
      seg("fl_off1", 7, 3, 3, 0, 2);
      seg("fl_on2", 7, 2, 2, 0, 2);
      seg("fl_off2", 7, 3, 3, 0, 1);
      flash_mode = 1'b0;
      seg("fl_arb", 5, 0, 0, 0, 1);
      seg("fl_nsg", 0, 1, 0, 0, 8);

      // Freeze five cycles in the middle of NS yellow
      seg("frz_nsy", 1, 2, 0, 0, 1);
      en = 1'b0;
      seg("frz_hold", 1, 2, 0, 0, 5);
      en = 1'b1;
      seg("frz_nsy2", 1, 2, 0, 0, 1);
      seg("frz_ara", 2, 0, 0, 0, 1);
      seg("frz_ewg", 3, 0, 1, 0, 3);

      // Asynchronous reset pulse of 13 ns mid EW green
      #1 rstn = 1'b0;
      #1 check_reset_state("mid_rst");
      #12 rstn = 1'b1;
      seg("rst_nsg", 0, 1, 0, 0, 8);
      seg("rst_nsy", 1, 2, 0, 0, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
